// File: rtl/alu_comm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_comm_pkg
// Purpose  : Shared types and helpers for the ALU datapath blocks.
//            - cmprs_acc_state_e : control states of the carry-save accumulator
//            - extend_operand    : sign/zero extension of an operand to 64 bits
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } cmprs_acc_state_e;

  // Extends the low 'width' bits of 'data' to 64 bits. Callers cast the result
  // down to their own accumulator width. 'width' must be in 1..63.
  function automatic logic [63:0] extend_operand(input logic [63:0] data,
                                                 input int          width,
                                                 input logic        is_signed);
    logic [63:0] mask;
    mask           = (64'd1 << width) - 64'd1;
    extend_operand = data & mask;
    if (is_signed && data[width-1]) begin
      extend_operand = extend_operand | ~mask;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmprs_3to2.sv
`default_nettype none
// ============================================================================
// Module   : cmprs_3to2
// Purpose  : Row of independent full adders (3:2 compressor). Each bit column
//            reduces three inputs to a sum bit and a carry bit; no carry
//            ripples between columns.
// Ports    : a, b, c [WIDTH-1:0]  in   three addends
//            sum      [WIDTH-1:0] out  bitwise XOR of the addends
//            cout     [WIDTH-1:0] out  bitwise majority (unshifted carries)
// Revision : 1.0 - initial release
// ============================================================================
module cmprs_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign cout[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

endmodule
`default_nettype wire

// File: rtl/cmprs_accum.sv
`default_nettype none
// ============================================================================
// Module   : cmprs_accum
// Purpose  : Multi-operand carry-save accumulator. Operands arrive one per
//            cycle on a valid/ready stream and are folded into a redundant
//            sum/carry pair with a 3:2 compressor row. After the last beat a
//            single carry-propagate add produces the result.
// Ports    : clk, rst                 clock / synchronous active-high reset
//            in_valid, in_ready       operand handshake
//            in_data  [WIDTH-1:0]     operand
//            in_signed                1: sign-extend, 0: zero-extend (per beat)
//            in_last                  final beat of the transaction
//            out_valid, out_ready     result handshake
//            out_data [ACC_WIDTH-1:0] sum of all beats modulo 2**ACC_WIDTH
//            out_ovf                  more than 2**GUARD beats were summed
// Revision : 1.0 - initial release
// ============================================================================
module cmprs_accum
  import alu_comm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GUARD     = 4,
  parameter int ACC_WIDTH = WIDTH + GUARD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_signed,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf
);

  localparam int CNT_W = GUARD + 2;
  localparam logic [CNT_W-1:0] c_beat_limit = CNT_W'(2**GUARD);

  cmprs_acc_state_e r_state;
  cmprs_acc_state_e w_next_state;

  logic [ACC_WIDTH-1:0] r_s;
  logic [ACC_WIDTH-1:0] r_c;
  logic [CNT_W-1:0]     r_count;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic                 w_release;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_s_in;
  logic [ACC_WIDTH-1:0] w_c_in;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_cout;
  logic [ACC_WIDTH-1:0] w_c_next;
  logic [CNT_W-1:0]     w_cnt_in;
  logic [CNT_W-1:0]     w_cnt_next;

  // Held low while reset is asserted so no beat is taken during the reset cycle.
  assign in_ready  = ~rst & ((r_state == IDLE) || (r_state == ACCUM));
  assign out_valid = (r_state == OUTPUT);
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  assign w_ext = ACC_WIDTH'(extend_operand(64'(in_data), WIDTH, in_signed));

  // The first beat of a transaction must not see leftovers in s/c/count.
  assign w_s_in   = (r_state == IDLE) ? '0 : r_s;
  assign w_c_in   = (r_state == IDLE) ? '0 : r_c;
  assign w_cnt_in = (r_state == IDLE) ? '0 : r_count;

  cmprs_3to2 #(
    .WIDTH (ACC_WIDTH)
  ) u_cmprs (
    .a    (w_s_in),
    .b    (w_c_in),
    .c    (w_ext),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Carry is stored already weighted by two; the MSB carry falls off (mod 2**ACC_WIDTH).
  assign w_c_next   = {w_cout[ACC_WIDTH-2:0], 1'b0};
  assign w_cnt_next = (&w_cnt_in) ? w_cnt_in : w_cnt_in + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_next_state = in_last ? RESOLVE : ACCUM;
        end
      end
      RESOLVE: w_next_state = OUTPUT;
      OUTPUT: begin
        if (w_release) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= '0;
      r_c        <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s     <= w_sum;
        r_c     <= w_c_next;
        r_count <= w_cnt_next;
      end
      if (r_state == RESOLVE) begin
        r_out_data <= r_s + r_c;
        r_out_ovf  <= (r_count > c_beat_limit);
      end
      if (w_release) begin
        r_s     <= '0;
        r_c     <= '0;
        r_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmprs_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmprs_accum
// Purpose  : Directed self-checking bench for cmprs_accum (WIDTH=8, GUARD=4).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmprs_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_signed;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmprs_accum #(
    .WIDTH (8),
    .GUARD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic sgn, input logic last);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = sgn;
    in_last   = last;
    step();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [11:0] exp_d, input logic exp_o);
    int waited = 0;
    while (!out_valid && waited < 8) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(exp_d));
    check({tag, "_ovf"},   32'(out_ovf),   32'(exp_o));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_drop"},  32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
    in_last = 1'b0; out_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single beat, latency T+2
    beat(8'h7F, 1'b0, 1'b1);
    check("t1_resolve_valid", 32'(out_valid), 32'd0);
    check("t1_resolve_ready", 32'(in_ready),  32'd0);
    step();
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    get_result("t1", 12'h07F, 1'b0);

    // 2: unsigned carries across beats
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b1);
    get_result("t2", 12'h1FF, 1'b0);

    // 3: signed, then mixed signedness
    beat(8'h80, 1'b1, 1'b0);
    beat(8'h7F, 1'b1, 1'b0);
    beat(8'hFF, 1'b1, 1'b1);
    get_result("t3_signed", 12'hFFE, 1'b0);
    beat(8'hFF, 1'b1, 1'b0);
    beat(8'hFF, 1'b0, 1'b1);
    get_result("t3_mixed", 12'h0FE, 1'b0);

    // 4: guard boundary
    for (int i = 0; i < 17; i++) beat(8'hFF, 1'b0, i == 16);
    get_result("t4_17", 12'h0EF, 1'b1);
    for (int i = 0; i < 16; i++) beat(8'hFF, 1'b0, i == 15);
    get_result("t4_16", 12'hFF0, 1'b0);

    // 5: output backpressure, ignored beats, clean next transaction
    beat(8'h10, 1'b0, 1'b0);
    beat(8'h20, 1'b0, 1'b1);
    step();
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_data",  32'(out_data),  32'h030);
      check("t5_hold_ready", 32'(in_ready),  32'd0);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("t5", 12'h030, 1'b0);
    beat(8'h03, 1'b0, 1'b1);
    get_result("t5_next", 12'h003, 1'b0);

    // 6: reset mid-transaction discards partial sums
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_ready", 32'(in_ready),  32'd1);
    beat(8'h05, 1'b0, 1'b1);
    get_result("t6", 12'h005, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
